// File: rtl/bufferm_rd_seq.sv
// bufferm_rd_seq: issues strided read bursts to bufferM and streams the returned words out through a credit-guarded FIFO.
// Optional feature macro: BUFM_RDSEQ_STALL_CNT_EN adds a saturating 16-bit downstream-stall counter output.
module bufferm_rd_seq #(
  parameter int addrLen    = 10,
  parameter int dataLen    = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [addrLen-1:0] base_addr,
  input  logic [addrLen-1:0] stride,
  input  logic [addrLen-1:0] count,
  output logic [addrLen-1:0] rd_addr,
  input  logic [dataLen-1:0] buf_data,
  output logic [dataLen-1:0] out_data,
  output logic               out_valid,
  input  logic               out_ready,
`ifdef BUFM_RDSEQ_STALL_CNT_EN
  output logic [15:0]        stall_cnt,
`endif
  output logic               busy,
  output logic               done
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW:0]   DEPTH_C  = (CW+1)'(FIFO_DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(FIFO_DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [addrLen-1:0] cur_addr_q, cur_addr_d;
  logic [addrLen-1:0] stride_q, stride_d;
  logic [addrLen-1:0] remaining_q, remaining_d;
  logic               inflight_q, inflight_d;
  logic [dataLen-1:0] mem_q [FIFO_DEPTH];
  logic [dataLen-1:0] mem_d [FIFO_DEPTH];
  logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      fifo_count_q, fifo_count_d;

  logic issue;
  logic push;
  logic pop;

  assign rd_addr   = cur_addr_q;
  assign out_data  = mem_q[rd_ptr_q];
  assign out_valid = (fifo_count_q != '0);
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);

  // The inflight flag marks a read whose data bufferM returns next cycle; it
  // holds a FIFO credit so a word is never pushed into a full FIFO.
  assign push  = inflight_q;
  assign pop   = out_valid && out_ready;
  assign issue = (state_q == S_RUN) && (remaining_q != '0) &&
                 (({1'b0, fifo_count_q} + (CW+1)'(inflight_q)) < DEPTH_C);

  always_comb begin
    mem_d        = mem_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    fifo_count_d = fifo_count_q + CW'(push) - CW'(pop);
    if (push) begin
      mem_d[wr_ptr_q] = buf_data;
      wr_ptr_d        = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PW'(1);
    end
  end

  // Completion looks at post-edge FIFO occupancy so done follows the final pop directly.
  always_comb begin
    state_d     = state_q;
    cur_addr_d  = cur_addr_q;
    stride_d    = stride_q;
    remaining_d = remaining_q;
    inflight_d  = issue;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          stride_d    = stride;
          remaining_d = count;
          if (count != '0) begin
            cur_addr_d = base_addr;
            state_d    = S_RUN;
          end else begin
            state_d    = S_DONE;
          end
        end
      end
      S_RUN: begin
        if (issue) begin
          cur_addr_d  = cur_addr_q + stride_q;
          remaining_d = remaining_q - addrLen'(1);
        end
        if ((remaining_q == '0) && !inflight_q && (fifo_count_d == '0)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      cur_addr_q   <= '0;
      stride_q     <= '0;
      remaining_q  <= '0;
      inflight_q   <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fifo_count_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      cur_addr_q   <= cur_addr_d;
      stride_q     <= stride_d;
      remaining_q  <= remaining_d;
      inflight_q   <= inflight_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      fifo_count_q <= fifo_count_d;
      mem_q        <= mem_d;
    end
  end

`ifdef BUFM_RDSEQ_STALL_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  assign stall_cnt = stall_cnt_q;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if ((state_q == S_IDLE) && start) begin
      stall_cnt_d = '0;
    end else if (out_valid && !out_ready && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end
`endif

endmodule

// File: tb/tb_bufferm_rd_seq.sv
// tb_bufferm_rd_seq: directed and randomized bursts against a ROM-backed bufferM model and an expected-word queue.
module tb_bufferm_rd_seq;

  localparam int AW    = 10;
  localparam int DW    = 32;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW-1:0] stride;
  logic [AW-1:0] count;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] buf_data;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          busy;
  logic          done;
`ifdef BUFM_RDSEQ_STALL_CNT_EN
  logic [15:0]   stall_cnt;
`endif

  always #5 clk = ~clk;

  bufferm_rd_seq #(.addrLen(AW), .dataLen(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .base_addr (base_addr),
    .stride    (stride),
    .count     (count),
    .rd_addr   (rd_addr),
    .buf_data  (buf_data),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef BUFM_RDSEQ_STALL_CNT_EN
    .stall_cnt (stall_cnt),
`endif
    .busy      (busy),
    .done      (done)
  );

  // bufferM behaviour: one-cycle registered read of a fixed ROM
  logic [DW-1:0] rom [1<<AW];
  always @(posedge clk) buf_data <= rom[rd_addr];

  int            checks = 0;
  int            errors = 0;
  int            popped = 0;
  logic [DW-1:0] exp_q [$];
  bit            credit_on = 1'b0;
  logic [AW-1:0] credit_base = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  // Scoreboard the word accepted at the coming edge, then advance one clock.
  task automatic tick();
    logic [AW-1:0] issued;
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("extra_word", 32'(out_valid), 32'd0);
      end else begin
        chk("data", out_data, exp_q[0]);
        void'(exp_q.pop_front());
      end
      popped++;
    end
    if (credit_on) begin
      issued = rd_addr - credit_base;
      chk("credit", 32'((int'(issued) - popped) <= DEPTH), 32'd1);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_burst(input logic [AW-1:0] b, input logic [AW-1:0] s, input int n, input bit interfere);
    logic [AW-1:0] a;
    for (int i = 0; i < n; i++) begin
      a = b + AW'(i) * s;
      exp_q.push_back(rom[a]);
    end
    base_addr = b;
    stride    = s;
    count     = AW'(n);
    start     = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k <= n + 3; k++) begin
      if (k < n) begin
        a = b + AW'(k) * s;
        chk("addr", 32'(rd_addr), 32'(a));
      end
      chk("valid", 32'(out_valid), 32'(k >= 2 && k <= n + 1));
      chk("done", 32'(done), 32'(k == n + 2));
      chk("busy", 32'(busy), 32'(k <= n + 2));
      start = interfere && (k == 1);
      if (start) begin
        base_addr = ~b;
        stride    = s + AW'(1);
        count     = AW'(3);
      end
      tick();
    end
    start = 1'b0;
    chk("drained", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) rom[i] = $urandom;
    reset = 1'b0; start = 1'b0; base_addr = '0; stride = '0; count = '0; out_ready = 1'b1;
    #1;
    chk("rst_rd_addr", 32'(rd_addr), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    tick(); tick();
    reset = 1'b1;
    tick();

    // count of zero: one DONE cycle, no reads, address untouched
    base_addr = 10'h155; stride = 10'd2; count = '0; start = 1'b1;
    tick();
    start = 1'b0;
    chk("zero_busy", 32'(busy), 32'd1);
    chk("zero_done", 32'(done), 32'd1);
    chk("zero_valid", 32'(out_valid), 32'd0);
    chk("zero_addr", 32'(rd_addr), 32'd0);
    tick();
    chk("zero_busy2", 32'(busy), 32'd0);
    chk("zero_done2", 32'(done), 32'd0);
    chk("zero_valid2", 32'(out_valid), 32'd0);
    chk("zero_addr2", 32'(rd_addr), 32'd0);

    run_burst(10'd5, 10'd1, 4, 1'b0);
    run_burst(10'h3FE, 10'd3, 3, 1'b0);
    run_burst(10'd200, 10'd2, 5, 1'b1);
    for (int r = 0; r < 4; r++) begin
      run_burst(AW'($urandom_range(0, 1023)), AW'($urandom_range(0, 1023)), $urandom_range(1, 12), 1'b0);
    end

    // backpressure: hold ready low for 6 cycles once the first word appears
    exp_q.delete();
    popped = 0;
    for (int i = 0; i < 10; i++) exp_q.push_back(rom[AW'(100 + i)]);
    base_addr = 10'd100; stride = 10'd1; count = 10'd10; start = 1'b1;
    tick();
    start = 1'b0;
    credit_base = 10'd100;
    credit_on   = 1'b1;
    for (int t = 0; t < 20 && out_valid !== 1'b1; t++) tick();
    chk("bp_first_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b0;
    for (int t = 0; t < 6; t++) begin
      chk("bp_hold_valid", 32'(out_valid), 32'd1);
      tick();
    end
    chk("bp_issued", 32'(rd_addr - 10'd100), 32'd4);
    chk("bp_popped0", 32'(popped), 32'd0);
`ifdef BUFM_RDSEQ_STALL_CNT_EN
    chk("bp_stall_cnt", 32'(stall_cnt), 32'd6);
`endif
    out_ready = 1'b1;
    for (int t = 0; t < 100 && done !== 1'b1; t++) tick();
    chk("bp_done", 32'(done), 32'd1);
    credit_on = 1'b0;
    chk("bp_drained", 32'(exp_q.size()), 32'd0);
    chk("bp_popped", 32'(popped), 32'd10);
`ifdef BUFM_RDSEQ_STALL_CNT_EN
    chk("bp_stall_final", 32'(stall_cnt), 32'd6);
`endif
    tick();

    // asynchronous reset after 3 of 8 words delivered
    exp_q.delete();
    popped = 0;
    for (int i = 0; i < 8; i++) exp_q.push_back(rom[AW'(300 + i)]);
    base_addr = 10'd300; stride = 10'd1; count = 10'd8; start = 1'b1;
    tick();
    start = 1'b0;
    for (int t = 0; t < 50 && popped < 3; t++) tick();
    chk("rst_mid_popped", 32'(popped), 32'd3);
    #2 reset = 1'b0;
    #1;
    chk("rst_mid_rd_addr", 32'(rd_addr), 32'd0);
    chk("rst_mid_out_data", out_data, 32'd0);
    chk("rst_mid_out_valid", 32'(out_valid), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_done", 32'(done), 32'd0);
`ifdef BUFM_RDSEQ_STALL_CNT_EN
    chk("rst_mid_stall_cnt", 32'(stall_cnt), 32'd0);
`endif
    exp_q.delete();
    tick(); tick();
    reset = 1'b1;
    tick();
    chk("post_rst_done", 32'(done), 32'd0);
    chk("post_rst_busy", 32'(busy), 32'd0);
    run_burst(AW'($urandom_range(0, 1023)), AW'($urandom_range(1, 1023)), $urandom_range(1, 12), 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
